// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tone_pkg
// Description : Note codes, half-period interval table and config record
//               shared by the tone bank.
// Revision    : 1.0 - initial release
// ============================================================================
package tone_pkg;

    localparam int NOTE_W     = 4;
    localparam int INTERVAL_W = 16;

    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd8;
    localparam logic [NOTE_W-1:0] NOTE_D5   = 4'd9;
    localparam logic [NOTE_W-1:0] NOTE_E5   = 4'd10;
    localparam logic [NOTE_W-1:0] NOTE_F5   = 4'd11;
    localparam logic [NOTE_W-1:0] NOTE_G5   = 4'd12;
    localparam logic [NOTE_W-1:0] NOTE_A5   = 4'd13;
    localparam logic [NOTE_W-1:0] NOTE_B5   = 4'd14;
    localparam logic [NOTE_W-1:0] NOTE_C6   = 4'd15;

    typedef struct packed {
        logic [INTERVAL_W-1:0] interval;
        logic [7:0]            duty;
    } tone_cfg_t;

    // Half-period in clk cycles at 12 MHz; rest yields a zero period.
    function automatic logic [INTERVAL_W-1:0] note_interval(input logic [NOTE_W-1:0] code);
        logic [INTERVAL_W-1:0] v;
        case (code)
            NOTE_C4: v = 16'd22940;
            NOTE_D4: v = 16'd20434;
            NOTE_E4: v = 16'd18204;
            NOTE_F4: v = 16'd17190;
            NOTE_G4: v = 16'd15306;
            NOTE_A4: v = 16'd13636;
            NOTE_B4: v = 16'd12148;
            NOTE_C5: v = 16'd11471;
            NOTE_D5: v = 16'd10217;
            NOTE_E5: v = 16'd9102;
            NOTE_F5: v = 16'd8595;
            NOTE_G5: v = 16'd7653;
            NOTE_A5: v = 16'd6818;
            NOTE_B5: v = 16'd6074;
            NOTE_C6: v = 16'd5736;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_channel.sv
`default_nettype none
// ============================================================================
// Module      : tone_channel
// Description : One PWM tone voice with shadowed config applied at wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_channel #(
    parameter int CNT_W  = 16,
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic              i_wr,
    input  logic [CNT_W-1:0]  i_interval,
    input  logic [DUTY_W-1:0] i_duty,
    output logic              o_pend,
    output logic              o_pwm,
    output logic              o_tick
);

    localparam int PROD_W = CNT_W + 1 + DUTY_W;
    localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

    logic [CNT_W-1:0]  r_sh_int;
    logic [DUTY_W-1:0] r_sh_duty;
    logic              r_pend;
    logic [CNT_W:0]    r_period;
    logic [CNT_W:0]    r_high;
    logic [CNT_W:0]    r_phase;
    logic              r_tick;
    logic              r_pwm;

    logic [CNT_W:0]    w_new_period;
    logic [PROD_W-1:0] w_prod;
    logic [CNT_W:0]    w_new_high;
    logic              w_active;
    logic              w_wrap;
    logic              w_apply;

    // Full-width product so the duty fraction is never truncated early.
    assign w_new_period = {r_sh_int, 1'b0};
    assign w_prod       = PROD_W'(w_new_period) * PROD_W'(r_sh_duty);
    assign w_new_high   = w_prod[PROD_W-1:DUTY_W];

    assign w_active = (r_period != '0);
    assign w_wrap   = w_active && (r_phase == (r_period - ONE));
    assign w_apply  = r_pend && i_enable && (!w_active || w_wrap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_int  <= '0;
            r_sh_duty <= {1'b1, {(DUTY_W-1){1'b0}}};
            r_pend    <= 1'b0;
            r_period  <= '0;
            r_high    <= '0;
            r_phase   <= '0;
            r_tick    <= 1'b0;
            r_pwm     <= 1'b0;
        end else begin
            // A write coinciding with apply lands in the shadow and stays pending.
            if (i_wr) begin
                r_sh_int  <= i_interval;
                r_sh_duty <= i_duty;
                r_pend    <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end

            if (i_enable) begin
                if (w_apply) begin
                    r_period <= w_new_period;
                    r_high   <= w_new_high;
                    r_phase  <= '0;
                end else if (w_wrap) begin
                    r_phase <= '0;
                end else if (w_active) begin
                    r_phase <= r_phase + ONE;
                end
            end

            r_tick <= i_enable && w_wrap;
            r_pwm  <= i_enable && w_active && (r_phase < r_high);
        end
    end

    assign o_pend = r_pend;
    assign o_pwm  = r_pwm;
    assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/tone_bank_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tone_bank_pwm
// Description : NUM_CH-voice PWM tone bank with config handshake and mix count.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_bank_pwm
    import tone_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int DUTY_W    = 8,
    parameter int OVERWRITE = 1,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int MIX_W    = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_chan,
    input  logic [3:0]        cfg_note,
    input  logic [DUTY_W-1:0] cfg_duty,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] period_tick,
    output logic [MIX_W-1:0]  mix_out
);

    logic              r_run;
    logic [MIX_W-1:0]  r_mix;

    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_pwm;
    logic [NUM_CH-1:0] w_tick;
    logic              w_sel_pend;
    logic              w_accept;
    logic [CNT_W-1:0]  w_interval;
    logic [MIX_W-1:0]  w_pop;

    assign w_interval = CNT_W'(note_interval(cfg_note));

    // Out-of-range channel numbers match no slot, so they are accepted and dropped.
    always_comb begin
        w_sel_pend = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(cfg_chan) == i) w_sel_pend = w_pend[i];
        end
    end

    assign cfg_ready = r_run && ((OVERWRITE != 0) || !w_sel_pend);
    assign w_accept  = cfg_valid && cfg_ready;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            tone_channel #(
                .CNT_W  (CNT_W),
                .DUTY_W (DUTY_W)
            ) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_enable   (enable),
                .i_wr       (w_accept && (32'(cfg_chan) == g)),
                .i_interval (w_interval),
                .i_duty     (cfg_duty),
                .o_pend     (w_pend[g]),
                .o_pwm      (w_pwm[g]),
                .o_tick     (w_tick[g])
            );
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pop = w_pop + MIX_W'(w_pwm[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_mix <= '0;
        end else begin
            r_run <= 1'b1;
            r_mix <= enable ? w_pop : '0;
        end
    end

    assign pwm_out     = w_pwm;
    assign period_tick = w_tick;
    assign mix_out     = r_mix;

endmodule
`default_nettype wire

// File: tb/tb_tone_bank_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_bank_pwm
// Description : Directed self-checking bench for tone_bank_pwm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_bank_pwm;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_ready_bp;
    logic [1:0] cfg_chan;
    logic [3:0] cfg_note;
    logic [7:0] cfg_duty;
    logic [3:0] pwm_out;
    logic [3:0] pwm_bp;
    logic [3:0] period_tick;
    logic [3:0] tick_bp;
    logic [2:0] mix_out;
    logic [2:0] mix_bp;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint edges   = 0;
    longint base    = 0;

    localparam longint A = 45931;

    tone_bank_pwm u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chan    (cfg_chan),
        .cfg_note    (cfg_note),
        .cfg_duty    (cfg_duty),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .mix_out     (mix_out)
    );

    tone_bank_pwm #(.OVERWRITE(0)) u_dut_bp (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready_bp),
        .cfg_chan    (cfg_chan),
        .cfg_note    (cfg_note),
        .cfg_duty    (cfg_duty),
        .pwm_out     (pwm_bp),
        .period_tick (tick_bp),
        .mix_out     (mix_bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait until the negedge following relative edge k (apply edge = 1).
    task automatic at(input longint k);
        while (edges < base + k) @(negedge clk);
        if (edges != base + k) begin
            n_fail++;
            $display("FAIL timing: observed edge %0d expected %0d", edges - base, k);
        end
    endtask

    task automatic write(input logic [1:0] ch, input logic [3:0] n, input logic [7:0] d);
        cfg_chan  = ch;
        cfg_note  = n;
        cfg_duty  = d;
        cfg_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
        cfg_chan = 2'd0; cfg_note = 4'd0; cfg_duty = 8'd0;
        #12;
        chk("rst_pwm",   pwm_out, 0);
        chk("rst_tick",  period_tick, 0);
        chk("rst_mix",   mix_out, 0);
        chk("rst_ready", cfg_ready, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("ready_out_of_rst",    cfg_ready, 1);
        chk("ready_bp_out_of_rst", cfg_ready_bp, 1);

        // E4 on ch0, then async reset mid-tone
        enable = 1'b1;
        write(2'd0, 4'd3, 8'd128);
        @(negedge clk);
        chk("e4_apply_cycle_low", pwm_out, 0);
        @(negedge clk);
        chk("e4_running", pwm_out, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pwm",   pwm_out, 0);
        chk("async_rst_mix",   mix_out, 0);
        chk("async_rst_tick",  period_tick, 0);
        chk("async_rst_ready", cfg_ready, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("silent_after_rst", pwm_out, 0);
        chk("mix_after_rst",    mix_out, 0);

        // Four C4 voices loaded while disabled, started on one edge
        enable = 1'b0;
        write(2'd0, 4'd1, 8'd128);
        write(2'd1, 4'd1, 8'd128);
        write(2'd2, 4'd1, 8'd128);
        write(2'd3, 4'd1, 8'd128);
        cfg_chan = 2'd0; #1;
        chk("bp_ready_pending_ch0", cfg_ready_bp, 0);
        chk("ovr_ready_pending",    cfg_ready, 1);
        cfg_chan = 2'd1; #1;
        chk("bp_ready_pending_ch1", cfg_ready_bp, 0);
        base = edges;
        enable = 1'b1;

        at(1);
        chk("apply_pwm_low",     pwm_out, 0);
        chk("bp_ready_after_ap", cfg_ready_bp, 1);
        at(2);   chk("all_high",   pwm_out, 4'hF);
                 chk("mix_lag",    mix_out, 0);
        at(3);   chk("mix_4",      mix_out, 4);
        at(100); chk("pre_dis",    pwm_out, 4'hF);
        enable = 1'b0;
        at(101); chk("dis_pwm",    pwm_out, 0);
                 chk("dis_mix",    mix_out, 0);
                 chk("dis_tick",   period_tick, 0);
        at(150); enable = 1'b1;
        at(151); chk("reen_pwm",   pwm_out, 4'hF);
        at(152); chk("reen_mix",   mix_out, 4);

        // Retune ch0 mid-period, reprogram others, double-write ch3
        at(1050); write(2'd0, 4'd5, 8'd128);
        at(1052); write(2'd1, 4'd6, 8'd64);
        at(1054); write(2'd2, 4'd15, 8'd0);
        at(1056); write(2'd3, 4'd2, 8'd128);
        cfg_note = 4'd10; cfg_valid = 1'b1; #1;
        chk("bp_second_write_blocked", cfg_ready_bp, 0);
        chk("ovr_second_write_ready",  cfg_ready, 1);
        @(posedge clk); @(negedge clk); cfg_valid = 1'b0;

        at(22991); chk("c4_last_high",  pwm_out, 4'hF);
        at(22992); chk("c4_first_low",  pwm_out, 0);
                   chk("mix_still_4",   mix_out, 4);
        at(22993); chk("mix_0",         mix_out, 0);
        at(45930); chk("no_tick_early", period_tick, 0);
        at(A);     chk("c4_wrap_tick",  period_tick, 4'hF);
                   chk("c4_wrap_pwm",   pwm_out, 0);

        at(A+1);     chk("new_cfg_pwm",    pwm_out, 4'b1011);
                     chk("new_cfg_tick",   period_tick, 0);
                     chk("bp_ready_ch3",   cfg_ready_bp, 1);
        at(A+2);     chk("mix_3",          mix_out, 3);
        at(A+6818);  chk("a4d64_last_hi",  pwm_out, 4'b1011);
        at(A+6819);  chk("a4d64_low",      pwm_out, 4'b1001);
        at(A+9102);  chk("e5_last_hi",     pwm_out, 4'b1001);
        at(A+9103);  chk("e5_low",         pwm_out, 4'b0001);
        at(A+11472); chk("c6_duty0_tick",  period_tick, 4'b0100);
                     chk("c6_duty0_pwm",   pwm_out, 4'b0001);
        at(A+15306); chk("g4_last_hi",     pwm_out, 4'b0001);
        at(A+15307); chk("g4_low",         pwm_out, 0);
        at(A+18204); chk("e5_tick",        period_tick, 4'b1000);
        at(A+27272); chk("a4_tick",        period_tick, 4'b0010);
        at(A+27273); chk("a4_e5_rehigh",   pwm_out, 4'b1010);
        at(A+30611); chk("g4_pre_tick",    period_tick, 0);
        at(A+30612); chk("g4_tick",        period_tick, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tone_bank_pwm.md
Name: tone_bank_pwm

Overview:
- Multi-channel successor to the single-voice square-wave tone generator.
- NUM_CH independent tone channels, each with programmable note and duty cycle.
- Note and duty changes are loaded through a valid/ready config port and applied glitch-free at period boundaries.
- Produces per-channel PWM outputs plus a registered mix count that feeds the downstream audio DAC/sigma-delta stage.

Parameters:
- NUM_CH, 4, number of tone channels (1..16).
- CNT_W, 16, width of the half-period interval from the note table.
- DUTY_W, 8, duty-cycle resolution; duty/2^DUTY_W = high fraction.
- OVERWRITE, 1, 1 = a new config to a channel with a pending update replaces it; 0 = backpressure until the pending update is applied.

Ports:
- clk  in  1  system clock, 12 MHz nominal.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  global run; 0 freezes all channels.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept.
- cfg_chan  in  max(1,$clog2(NUM_CH))  target channel.
- cfg_note  in  4  note code.
- cfg_duty  in  DUTY_W  duty value.
- pwm_out  out  NUM_CH  per-channel tone output, registered.
- period_tick  out  NUM_CH  one-cycle pulse when a channel wraps its period.
- mix_out  out  $clog2(NUM_CH+1)  count of channels currently high, registered.

Behaviour:
- Reset (async, rst_n=0):
  - all phase counters 0; all channels at rest (period 0); pending flags clear; shadow duty = 2^(DUTY_W-1).
  - pwm_out, period_tick, mix_out = 0; cfg_ready = 0.
- Handshake:
  - accept when cfg_valid && cfg_ready at a rising edge; on accept, shadow[cfg_chan] <= {interval(cfg_note), cfg_duty}, pend[cfg_chan] <= 1.
  - cfg_chan >= NUM_CH: accepted and dropped.
  - OVERWRITE=1: cfg_ready = 1 whenever out of reset.
  - OVERWRITE=0: cfg_ready = !pend[cfg_chan] (combinational from cfg_chan).
- Per channel i, active registers: period = 2*interval (CNT_W+1 bits), high = (period*duty) >> DUTY_W (computed once at apply, CNT_W+1 bits).
- Phase counter:
  - counts 0..period-1, advancing one per enabled cycle.
  - at period-1 it wraps to 0, and period_tick[i] pulses on the following cycle.
  - held at 0 when period == 0.
- Apply:
  - condition: pend[i] && enable && (period == 0 || phase == period-1).
  - on apply: period, high <= shadow-derived values; phase <= 0; pend[i] <= 0.
- Simultaneous accept and apply on the same channel: the apply uses the old shadow; the new write sets shadow and leaves pend = 1.
- Output:
  - pwm_out[i] at t+1 = enable && period != 0 && phase(t) < high (1-cycle latency).
  - duty 0 gives a constant low output.
  - mix_out at t+1 = popcount(pwm_out(t)).
- enable = 0: counters, pend and shadow hold; pwm_out, period_tick, mix_out forced 0 next cycle. Config accepts are still taken.
- Note table (half-period interval, 4-bit code):
  - 0 rest = 0
  - 1 C4 22940, 2 D4 20434, 3 E4 18204, 4 F4 17190, 5 G4 15306, 6 A4 13636, 7 B4 12148, 8 C5 11471
  - 9 D5 10217, 10 E5 9102, 11 F5 8595, 12 G5 7653, 13 A5 6818, 14 B5 6074, 15 C6 5736
- Default duty 2^(DUTY_W-1) gives high = interval exactly, i.e. a 50 % square wave at clk/(2*interval).
- Arithmetic: product period*duty is CNT_W+1+DUTY_W bits wide, with no truncation before the shift.

Decomposition:
- Package tone_pkg contains:
  - note code localparams NOTE_REST..NOTE_C6;
  - function note_interval(code) returning the CNT_W table above;
  - typedef tone_cfg_t {interval, duty}.
- Sub-module tone_channel holds one channel's shadow, pend flag, period/high registers, phase counter, tick and output register. It is instantiated NUM_CH times by generate.
- Top level holds handshake decode, channel select and the mix popcount register.

Test Plan:
- Reset: assert rst_n=0 mid-tone on ch0 (E4) -> pwm_out, mix_out, period_tick, cfg_ready = 0 immediately; after release ch0 silent until reconfigured.
- Basic tone: ch0 C4, duty 128, enable=1 -> pwm_out[0] high 22940 cycles, low 22940; period_tick[0] every 45880 cycles.
- Duty: ch1 A4, duty 64 -> high 6818, low 20454, period 27272; duty 0 -> constant low; ticks continue.
- Glitch-free retune: ch0 C4 running, write G4 at phase 1000 -> C4 period completes fully; new period 30612 starts at phase 0 the cycle after the tick.
- Backpressure (OVERWRITE=0): two back-to-back writes to ch2 while tone active -> cfg_ready low on second until apply. With OVERWRITE=1, the second write wins and only the second note is heard.
- Mix/enable: ch0..3 all C4 duty 128 configured same cycle from rest -> mix_out 4 then 0 alternating every 22940 cycles. Drop enable -> all outputs 0 next cycle, phases resume on re-enable.
